telemetry_framer: RTL
=====================

# telemetry_framer

Periodic downlink framer between the sensor register bank and the 115200-baud data-link `serial_tx`. Every `PERIOD` clocks it snapshots the flattened sensor payload (altimeter, IMU, GPS fields). It wraps the payload in a framed, sequenced, checksummed packet. It then streams the packet byte-by-byte into `serial_tx` using the `new_data`/`busy` handshake.

## Interface
- `PERIOD`, 5_000_000: clocks between frame starts (10 Hz at 50 MHz); legal range 64..2^32-1.
- `PAYLOAD_BYTES`, 42: payload length in bytes; legal range 1..255.
- `clk` in 1: system clock. Every port below except `rst` is synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: frame starts are permitted while high.
- `payload` in 8*PAYLOAD_BYTES: flat sensor bus; byte 0 = `payload[8*PAYLOAD_BYTES-1 -: 8]`.
  - Top-level byte order: pressure(3), alt_temp(2), gyro_temp(2), gyro_x/y/z(6), accl_x/y/z(6), magm_x/y/z(6), lat_deg(1), lat_submins(3), lon_deg(1), lon_submins(3), gps_status(1), gps_time(4), ground_speed(4).
  - All multi-byte fields are big-endian.
- `tx_data` out 8: byte to `serial_tx.data`.
- `tx_new_data` out 1: single-cycle strobe to `serial_tx.new_data`.
- `tx_busy` in 1: from `serial_tx.busy`.
- `busy` out 1: high from the SNAP state until the checksum byte is accepted.
- `seq` out 8: sequence number carried by the next frame.
- `frames_dropped` out 8: saturating count of period ticks lost to a busy framer or a low `enable`.

## Operation
- Frame layout, `PAYLOAD_BYTES+5` bytes in this order:
  - 0xA5, 0x5A (sync)
  - `seq`
  - `PAYLOAD_BYTES` (length byte)
  - payload bytes 0..N-1
  - `CHK`
- `CHK` = 8-bit modulo-256 sum of the seq byte, the length byte and every payload byte. Sync bytes are excluded.
- Period counter:
  - Free-runs 0..PERIOD-1 and wraps.
  - Emits `tick` for one cycle when it is at PERIOD-1.
  - Counts regardless of `enable` and framer state.
- State machine:
  - IDLE: on `tick` with `enable`=1 go to SNAP. A `tick` with `enable`=0 increments `frames_dropped`.
  - SNAP: one cycle. Registers `payload` into the snapshot buffer, clears the byte index and checksum accumulator, then goes to SEND.
  - SEND: if `tx_busy`=0, drive `tx_data` = frame byte[index], pulse `tx_new_data`, add the byte to the accumulator (bytes 2..N+3 only), then go to HOLD. Otherwise stay in SEND.
  - HOLD: exactly one cycle, with `tx_busy` ignored. This covers `serial_tx` raising busy one cycle after the strobe. Then go to WAIT.
  - WAIT: on `tx_busy`=0, if index was the last byte go to IDLE and increment `seq`; otherwise increment index and go to SEND.
- `tick` while `busy`=1: the tick is ignored, `frames_dropped` increments, and the current frame is not disturbed.
- `frames_dropped` saturates at 255. `seq` wraps 255 -> 0.
- `enable` falling mid-frame: the current frame completes normally.
- Payload changes after SNAP do not affect the frame in flight.
- `tx_data` holds its last value when no strobe is issued. Its value is only meaningful while `tx_new_data`=1.

## Timing
- Reset values:
  - `tx_data`=0x00, `tx_new_data`=0, `busy`=0, `seq`=0x00, `frames_dropped`=0x00.
  - State=IDLE, period counter=0.
- Reset asserted mid-frame: outputs return to reset values asynchronously. No partial-frame resume after reset.
- Latency from `tick` (cycle T) to frame start:
  - SNAP at T+1.
  - First `tx_new_data` at T+2 if `tx_busy`=0.
- Byte cadence: minimum 3 cycles between strobes (SEND, HOLD, WAIT), otherwise paced by `tx_busy`.
- `tx_new_data` is never high on two consecutive cycles. It is never asserted while `tx_busy`=1.
- The last-byte acceptance cycle is the WAIT exit.
  - `busy` falls and `seq` updates on the following edge.
  - A `tick` on that same cycle counts as dropped.

## Structure
- Package `telemetry_pkg`:
  - `SYNC0`=8'hA5, `SYNC1`=8'h5A.
  - Header length 4, trailer length 1.
  - State enum {IDLE, SNAP, SEND, HOLD, WAIT}.
  - Payload field offset constants used by the top level to build `payload`.
- Sub-module `telemetry_tick_gen`: parameterised period counter producing `tick`.
- Byte select is a combinational mux on index:
  - header when index < 4
  - payload[index-4] when 4 <= index < N+4
  - `CHK` at index N+4.

## Test plan
- All-zero payload, `tx_busy` tied 0, first tick:
  - Required bytes: A5 5A 00 2A, then 42×00, then 2A.
  - Strobes spaced exactly 3 cycles; `seq` becomes 01.
- Payload bytes 0..41 = 0x01..0x2A, `seq`=0x05:
  - Required `CHK` = (0x05 + 0x2A + 903) mod 256 = 0xB6.
- Bench `serial_tx` model with 4340-cycle busy:
  - Never `tx_new_data` while busy.
  - 47 strobes per frame.
  - Second tick mid-frame increments `frames_dropped` to 1 without corrupting the frame.
- `enable`=0 for 3 ticks → `frames_dropped`=3 and no strobes. Drop `enable` mid-frame → that frame still completes with all 47 bytes.
- Modify `payload` 1 cycle after SNAP → transmitted frame carries the pre-change values.
- Assert `rst` at byte 20 → outputs zero immediately; after release, the next tick emits a full frame with `seq`=00.

Source files
------------

// File: rtl/telemetry_pkg.sv
// telemetry_pkg
//   Shared constants and types for the telemetry downlink framer:
//   sync bytes, header/trailer sizes, the framer state encoding and the
//   byte offsets of each sensor field inside the flat payload bus.
//   Byte 0 of the payload is the most significant byte of the bus, and
//   every multi-byte field is big-endian.
package telemetry_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  // Header = sync0, sync1, seq, length. Trailer = checksum.
  localparam int HDR_LEN = 4;
  localparam int TRL_LEN = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    SEND = 3'd2,
    HOLD = 3'd3,
    WAIT = 3'd4
  } state_t;

  // Field lengths in bytes, in payload order.
  localparam int LEN_PRESSURE     = 3;
  localparam int LEN_ALT_TEMP     = 2;
  localparam int LEN_GYRO_TEMP    = 2;
  localparam int LEN_GYRO_XYZ     = 6;
  localparam int LEN_ACCL_XYZ     = 6;
  localparam int LEN_MAGM_XYZ     = 6;
  localparam int LEN_LAT_DEG      = 1;
  localparam int LEN_LAT_SUBMINS  = 3;
  localparam int LEN_LON_DEG      = 1;
  localparam int LEN_LON_SUBMINS  = 3;
  localparam int LEN_GPS_STATUS   = 1;
  localparam int LEN_GPS_TIME     = 4;
  localparam int LEN_GROUND_SPEED = 4;

  // Byte offsets of each field from payload byte 0. Chained so that a
  // length change in one field moves everything after it.
  localparam int OFF_PRESSURE     = 0;
  localparam int OFF_ALT_TEMP     = OFF_PRESSURE     + LEN_PRESSURE;
  localparam int OFF_GYRO_TEMP    = OFF_ALT_TEMP     + LEN_ALT_TEMP;
  localparam int OFF_GYRO_XYZ     = OFF_GYRO_TEMP    + LEN_GYRO_TEMP;
  localparam int OFF_ACCL_XYZ     = OFF_GYRO_XYZ     + LEN_GYRO_XYZ;
  localparam int OFF_MAGM_XYZ     = OFF_ACCL_XYZ     + LEN_ACCL_XYZ;
  localparam int OFF_LAT_DEG      = OFF_MAGM_XYZ     + LEN_MAGM_XYZ;
  localparam int OFF_LAT_SUBMINS  = OFF_LAT_DEG      + LEN_LAT_DEG;
  localparam int OFF_LON_DEG      = OFF_LAT_SUBMINS  + LEN_LAT_SUBMINS;
  localparam int OFF_LON_SUBMINS  = OFF_LON_DEG      + LEN_LON_DEG;
  localparam int OFF_GPS_STATUS   = OFF_LON_SUBMINS  + LEN_LON_SUBMINS;
  localparam int OFF_GPS_TIME     = OFF_GPS_STATUS   + LEN_GPS_STATUS;
  localparam int OFF_GROUND_SPEED = OFF_GPS_TIME     + LEN_GPS_TIME;

  // Total sensor payload size (42 bytes).
  localparam int SENSOR_PAYLOAD_BYTES = OFF_GROUND_SPEED + LEN_GROUND_SPEED;

endpackage

// File: rtl/telemetry_tick_gen.sv
// telemetry_tick_gen
//   Free-running period counter. Counts 0..PERIOD-1 and wraps, and
//   raises tick for the single cycle in which the count is PERIOD-1.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (count returns to 0)
//   tick out one-cycle pulse once every PERIOD clocks
module telemetry_tick_gen #(
  parameter logic [31:0] PERIOD = 32'd5_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign tick = (cnt_q == (PERIOD - 32'd1));

  always_comb begin
    cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/telemetry_framer.sv
// telemetry_framer
//   Periodic downlink framer. Every PERIOD clocks it snapshots the flat
//   sensor payload and streams
//     A5 5A seq len payload[0..N-1] chk
//   byte by byte into a serial transmitter over a new_data/busy handshake.
//   chk is the modulo-256 sum of seq, len and all payload bytes.
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   enable         in   frame starts are permitted while high
//   payload        in   flat sensor bus, byte 0 in the top 8 bits
//   tx_data        out  byte to the transmitter, valid with tx_new_data
//   tx_new_data    out  single-cycle strobe to the transmitter
//   tx_busy        in   transmitter busy
//   busy           out  high from the snapshot until the checksum is accepted
//   seq            out  sequence number carried by the next frame
//   frames_dropped out  saturating count of period ticks that started no frame
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter logic [31:0] PERIOD        = 32'd5_000_000,
  parameter int          PAYLOAD_BYTES = SENSOR_PAYLOAD_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [8*PAYLOAD_BYTES-1:0]   payload,
  output logic [7:0]                   tx_data,
  output logic                         tx_new_data,
  input  logic                         tx_busy,
  output logic                         busy,
  output logic [7:0]                   seq,
  output logic [7:0]                   frames_dropped
);

  localparam int          PW       = 8 * PAYLOAD_BYTES;
  localparam logic [8:0]  HDR_IDX  = 9'(HDR_LEN);
  localparam logic [8:0]  SEQ_IDX  = 9'd2;
  // Index of the checksum byte, which is also the last byte of the frame.
  localparam logic [8:0]  CHK_IDX  = 9'(HDR_LEN + PAYLOAD_BYTES + TRL_LEN - 1);
  localparam logic [7:0]  LEN_BYTE = 8'(PAYLOAD_BYTES);

  state_t        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [PW-1:0] snap_q, snap_d;

  logic          tick;
  logic          strobe;
  logic [7:0]    frame_byte;

  telemetry_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // The strobe is issued in the SEND cycle itself so the first byte leaves
  // two cycles after the tick; gating on tx_busy here guarantees no strobe
  // is ever presented to a busy transmitter.
  assign strobe         = (state_q == SEND) && !tx_busy;
  assign tx_new_data    = strobe;
  assign tx_data        = strobe ? frame_byte : tx_data_q;
  assign busy           = (state_q != IDLE);
  assign seq            = seq_q;
  assign frames_dropped = drop_q;

  // Frame byte select. The snapshot is consumed as a shift register, so
  // the current payload byte is always in its top 8 bits.
  always_comb begin
    frame_byte = chk_q;
    if (idx_q < HDR_IDX) begin
      case (idx_q[1:0])
        2'd0:    frame_byte = SYNC0;
        2'd1:    frame_byte = SYNC1;
        2'd2:    frame_byte = seq_q;
        default: frame_byte = LEN_BYTE;
      endcase
    end else if (idx_q < CHK_IDX) begin
      frame_byte = snap_q[PW-1 -: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    seq_d     = seq_q;
    drop_d    = drop_q;
    tx_data_d = tx_data_q;
    snap_d    = snap_q;

    // A tick that cannot start a frame is counted, whether the framer is
    // busy (including the final WAIT cycle) or disabled.
    if (tick && (state_q != IDLE || !enable) && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = SNAP;
        end
      end
      SNAP: begin
        snap_d  = payload;
        idx_d   = 9'd0;
        chk_d   = 8'd0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d = frame_byte;
          if (idx_q >= SEQ_IDX && idx_q < CHK_IDX) begin
            chk_d = chk_q + frame_byte;
          end
          if (idx_q >= HDR_IDX && idx_q < CHK_IDX) begin
            snap_d = snap_q << 8;
          end
          state_d = HOLD;
        end
      end
      // The transmitter raises busy one cycle after the strobe, so busy is
      // not trusted until WAIT.
      HOLD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (idx_q == CHK_IDX) begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 9'd0;
      chk_q     <= 8'd0;
      seq_q     <= 8'd0;
      drop_q    <= 8'd0;
      tx_data_q <= 8'd0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      tx_data_q <= tx_data_d;
      snap_q    <= snap_d;
    end
  end

endmodule
